// File: rtl/imem_ctrl_pkg.sv
// ============================================================================
// Module      : imem_ctrl_pkg
// Description : Shared widths and state encoding for the instruction-memory
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    IMEM_IDLE     = 2'd0,
    IMEM_WAIT_GNT = 2'd1,
    IMEM_WAIT_RSP = 2'd2
  } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_ctrl.sv
// ============================================================================
// Module      : imem_ctrl
// Description : Fetch-side instruction-memory controller. Single-outstanding
//               bus initiator with a one-entry instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  input  logic                   imem_flush,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   instr_read_error,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_err
);

  // Only word addresses are tracked; the byte offset is fetch's concern.
  imem_state_e            state, state_d;
  logic [ADDR_WIDTH-1:2]  cur_word, pend_word, pend_d, req_word, req_d;
  logic [ADDR_WIDTH-1:2]  next_word, addr_word;
  logic [ADDR_WIDTH-1:2]  buf_word;
  logic [INSTR_WIDTH-1:0] buf_data;
  logic                   buf_valid;
  logic                   req;
  logic                   rsp_retire, hit_next, bus_hit, buf_hit_cur, fill;
  logic                   unused_lsbs;

  assign next_word   = next_pc[ADDR_WIDTH-1:2];
  assign unused_lsbs = &{1'b0, next_pc[1:0], boot_addr[1:0]};

  // A response is only meaningful while a transaction is pending; anything
  // else (e.g. the tail of a transaction abandoned by reset) is ignored.
  assign rsp_retire  = (state == IMEM_WAIT_RSP) && imem_rvalid;
  assign hit_next    = buf_valid && (buf_word == next_word);
  assign bus_hit     = rsp_retire && (pend_word == cur_word);
  assign buf_hit_cur = buf_valid && (buf_word == cur_word);
  assign fill        = rsp_retire && !imem_err;

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state <= IMEM_IDLE;
    else         state <= state_d;
  end

  // Address tracking and instruction buffer; flush overrides a same-cycle fill.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      cur_word  <= boot_addr[ADDR_WIDTH-1:2];
      pend_word <= '0;
      req_word  <= '0;
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else begin
      cur_word  <= next_word;
      pend_word <= pend_d;
      req_word  <= req_d;
      if (fill) begin
        buf_valid <= 1'b1;
        buf_word  <= pend_word;
        buf_data  <= imem_rdata;
      end
      if (imem_flush) buf_valid <= 1'b0;
    end
  end

  // Next-state and bus request; a request parked in WAIT_GNT is never
  // withdrawn or re-addressed, even when fetch redirects.
  always_comb begin
    state_d   = state;
    pend_d    = pend_word;
    req_d     = req_word;
    req       = 1'b0;
    addr_word = next_word;
    case (state)
      IMEM_IDLE: begin
        if (!hit_next) begin
          req = 1'b1;
          if (imem_gnt) begin
            state_d = IMEM_WAIT_RSP;
            pend_d  = next_word;
          end else begin
            state_d = IMEM_WAIT_GNT;
            req_d   = next_word;
          end
        end
      end
      IMEM_WAIT_GNT: begin
        req       = 1'b1;
        addr_word = req_word;
        if (imem_gnt) begin
          state_d = IMEM_WAIT_RSP;
          pend_d  = req_word;
        end
      end
      IMEM_WAIT_RSP: begin
        if (imem_rvalid) begin
          // The arriving word covers next_pc == pend_word without a new request.
          if (!hit_next && (next_word != pend_word)) begin
            req = 1'b1;
            if (imem_gnt) begin
              pend_d = next_word;
            end else begin
              state_d = IMEM_WAIT_GNT;
              req_d   = next_word;
            end
          end else begin
            state_d = IMEM_IDLE;
          end
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // Fetch-facing outputs; the bus path takes priority over the buffer.
  always_comb begin
    imem_req              = req && !cpu_rst;
    imem_addr             = {addr_word, 2'b00};
    instr_read_data_valid = !cpu_rst && (bus_hit || buf_hit_cur);
    instr_read_error      = !cpu_rst && bus_hit && imem_err;
    instr_read_data       = '0;
    if (!cpu_rst) begin
      if (bus_hit)          instr_read_data = imem_err ? '0 : imem_rdata;
      else if (buf_hit_cur) instr_read_data = buf_data;
    end
  end

endmodule

`default_nettype wire
